// File: rtl/runner_game_core.sv
// -----------------------------------------------------------------------------
// runner_game_core
//
// Core of a side-scrolling runner game. The player box sits at a fixed column
// and can jump. Obstacles scroll in from the right edge. When an obstacle leaves
// on the left it respawns at a pseudo-random offset past the right edge, and the
// score counts one. When the player box and an obstacle box overlap, the game
// ends. Game state changes only on frame strobes. The pixel colour for the
// current beam position is produced every clock.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset
//   tick       one-clock frame strobe; all game state advances on it
//   jump       jump request (level)
//   start      start / restart request (level)
//   x, y       current pixel column / row
//   red        pixel red   (5 bits), registered, one clock after x/y
//   green      pixel green (6 bits), registered, one clock after x/y
//   blue       pixel blue  (5 bits), registered, one clock after x/y
//   player_y   row of the player's bottom edge
//   score      obstacles cleared, saturating
//   game_over  high while the game sits in the OVER state
// -----------------------------------------------------------------------------
module runner_game_core #(
    parameter int SCREEN_W = 480,
    parameter int SCREEN_H = 272,
    parameter int PLAYER_X = 40,
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 20,
    parameter int GROUND_Y = 180,
    parameter int N_OBST   = 3,
    parameter int OBST_W   = 10,
    parameter int OBST_H   = 20,
    parameter int OBST_GAP = 160,
    parameter int SPEED    = 2,
    parameter int JUMP_V0  = 8,
    parameter int GRAVITY  = 1,
    parameter int SCORE_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               jump,
    input  logic               start,
    input  logic [8:0]         x,
    input  logic [8:0]         y,
    output logic [4:0]         red,
    output logic [5:0]         green,
    output logic [4:0]         blue,
    output logic [8:0]         player_y,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    // All geometry comparisons use a 12-bit working width. This leaves
    // headroom for sums such as ox + OBST_W, so no result wraps.
    localparam int CW = 12;

    localparam logic [CW-1:0] C_SCREEN_W = CW'(SCREEN_W);
    localparam logic [CW-1:0] C_SCREEN_H = CW'(SCREEN_H);
    localparam logic [CW-1:0] C_PX_L     = CW'(PLAYER_X);
    localparam logic [CW-1:0] C_PX_R     = CW'(PLAYER_X + PLAYER_W);
    localparam logic [CW-1:0] C_PLAYER_H = CW'(PLAYER_H);
    localparam logic [CW-1:0] C_GROUND_Y = CW'(GROUND_Y);
    localparam logic [CW-1:0] C_OBST_W   = CW'(OBST_W);
    localparam logic [CW-1:0] C_OBST_TOP = CW'(GROUND_Y - OBST_H);

    localparam logic [8:0]        GROUND_9   = 9'(GROUND_Y);
    localparam logic [9:0]        SPEED_10   = 10'(SPEED);
    localparam logic [9:0]        SCREEN_10  = 10'(SCREEN_W);
    localparam logic signed [7:0] V0         = 8'(JUMP_V0);
    localparam logic signed [7:0] GRAV       = 8'(GRAVITY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t               state, state_next;
    logic [8:0]           py, py_next;
    logic signed [7:0]    vy, vy_next;
    logic [SCORE_W-1:0]   score_q, score_next;
    logic [9:0]           ox      [N_OBST];
    logic [9:0]           ox_next [N_OBST];
    logic [7:0]           lfsr, lfsr_next;

    // Candidate values for a RUN tick, computed whatever the current state.
    logic [8:0]           run_py;
    logic signed [7:0]    run_vy;
    logic signed [CW-1:0] py_sum;
    logic [9:0]           run_ox  [N_OBST];
    logic [3:0]           hits;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   run_score;
    logic                 collide;

    logic [4:0]           pix_r;
    logic [5:0]           pix_g;
    logic [4:0]           pix_b;

    // Starting column of slot i, used both on reset and on (re)start.
    function automatic logic [9:0] slot_home(input int i);
        return 10'(SCREEN_W + i * OBST_GAP);
    endfunction

    // Respawn offset for slot i. This is the LFSR rotated left by the slot
    // index, reduced to 0..127, so that slots respawning on the same frame
    // do not stack on top of each other.
    function automatic logic [9:0] respawn_offset(input logic [7:0] v, input int i);
        logic [15:0] both;
        logic [9:0]  rot;
        both = {v, v} << i;
        rot  = {2'b00, both[15:8]};
        return rot & 10'h07F;
    endfunction

    // Galois-free Fibonacci LFSR for x^8+x^6+x^5+x^4+1. It steps on every
    // frame in every state, so each time the game restarts the respawn
    // pattern continues from a different point.
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Player vertical motion. A jump can only start from rest on the ground.
    // On the start frame the height is unchanged and only the upward speed
    // is loaded. When the player reaches or passes the ground line, the
    // height is pinned to the ground and the speed is cleared.
    always_comb begin
        py_sum = $signed({3'b000, py}) + $signed({{4{vy[7]}}, vy});
        run_py = py;
        run_vy = vy;
        if (py == GROUND_9 && vy == 8'sd0 && jump) begin
            run_vy = -V0;
        end else if (py_sum >= $signed(C_GROUND_Y)) begin
            run_py = GROUND_9;
            run_vy = 8'sd0;
        end else begin
            run_py = py_sum[8:0];
            run_vy = vy + GRAV;
        end
    end

    // Obstacle scroll and respawn. The respawn test looks at the position
    // before this frame's move. Every slot that respawns adds one point.
    // The score saturates instead of wrapping to zero.
    always_comb begin
        hits = 4'd0;
        for (int i = 0; i < N_OBST; i++) begin
            if (ox[i] <= SPEED_10) begin
                run_ox[i] = SCREEN_10 + respawn_offset(lfsr, i);
                hits      = hits + 4'd1;
            end else begin
                run_ox[i] = ox[i] - SPEED_10;
            end
        end
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hits);
        run_score = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Strict overlap between the player box and any obstacle box, using the
    // positions after this frame's move. Boxes whose edges only touch do not
    // collide. The player-top test is rearranged as py < GROUND_Y + PLAYER_H,
    // so no subtraction can go negative.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < N_OBST; i++) begin
            if ((CW'(run_ox[i]) < C_PX_R) &&
                (CW'(run_ox[i]) + C_OBST_W > C_PX_L) &&
                (CW'(run_py) < C_GROUND_Y + C_PLAYER_H) &&
                (CW'(run_py) > C_OBST_TOP)) begin
                collide = 1'b1;
            end
        end
    end

    // Next-state and next-value selection. IDLE and OVER hold everything
    // until a start request. A start request reloads the starting layout.
    // In RUN the candidate values are taken, and the state moves to OVER on
    // the frame where a collision is detected. The score from that frame is
    // kept.
    always_comb begin
        state_next = state;
        py_next    = py;
        vy_next    = vy;
        score_next = score_q;
        ox_next    = ox;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_next = RUN;
                    py_next    = GROUND_9;
                    vy_next    = 8'sd0;
                    score_next = '0;
                    for (int i = 0; i < N_OBST; i++) begin
                        ox_next[i] = slot_home(i);
                    end
                end
            end
            RUN: begin
                py_next    = run_py;
                vy_next    = run_vy;
                score_next = run_score;
                ox_next    = run_ox;
                if (collide) begin
                    state_next = OVER;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Game state register. The asynchronous reset restores the starting
    // layout immediately, even in the middle of a jump. Otherwise state
    // changes only on a frame strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            py      <= GROUND_9;
            vy      <= 8'sd0;
            score_q <= '0;
            lfsr    <= 8'hA5;
            for (int i = 0; i < N_OBST; i++) begin
                ox[i] <= slot_home(i);
            end
        end else if (tick) begin
            state   <= state_next;
            py      <= py_next;
            vy      <= vy_next;
            score_q <= score_next;
            lfsr    <= lfsr_next;
            ox      <= ox_next;
        end
    end

    // Pixel colour, highest priority first: player, obstacle, ground, sky.
    // Anything outside the visible area is forced to black. Without that,
    // respawned obstacles sitting past the right edge would be drawn there.
    always_comb begin
        logic on_player;
        logic on_obst;
        pix_r     = 5'd0;
        pix_g     = 6'd0;
        pix_b     = 5'd0;
        on_player = (CW'(x) >= C_PX_L) && (CW'(x) < C_PX_R) &&
                    (CW'(y) + C_PLAYER_H >= CW'(py)) && (CW'(y) < CW'(py));
        on_obst   = 1'b0;
        for (int i = 0; i < N_OBST; i++) begin
            if ((CW'(x) >= CW'(ox[i])) && (CW'(x) < CW'(ox[i]) + C_OBST_W) &&
                (CW'(y) >= C_OBST_TOP) && (CW'(y) < C_GROUND_Y)) begin
                on_obst = 1'b1;
            end
        end
        if ((CW'(x) >= C_SCREEN_W) || (CW'(y) >= C_SCREEN_H)) begin
            pix_r = 5'd0;
        end else if (on_player) begin
            if (state == OVER) begin
                pix_r = 5'd31;
            end else begin
                pix_b = 5'd31;
            end
        end else if (on_obst) begin
            pix_g = 6'd40;
        end else if (CW'(y) >= C_GROUND_Y) begin
            pix_g = 6'd63;
        end else begin
            pix_g = 6'd30;
            pix_b = 5'd20;
        end
    end

    // Colour output register. It updates every clock, so the colour appears
    // one clock after the beam position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red   <= 5'd0;
            green <= 6'd0;
            blue  <= 5'd0;
        end else begin
            red   <= pix_r;
            green <= pix_g;
            blue  <= pix_b;
        end
    end

    assign player_y  = py;
    assign score     = score_q;
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_runner_game_core.sv
// -----------------------------------------------------------------------------
// tb_runner_game_core
//
// Drives two copies of runner_game_core from the same stimulus: one with
// default parameters, and one with SPEED=4. Obstacles move faster in the
// second copy, so a single jump can carry the player over an obstacle.
// Outputs are compared with a frame-level model of the game rules.
// -----------------------------------------------------------------------------
module tb_runner_game_core;

    localparam int SCREEN_W = 480;
    localparam int SCREEN_H = 272;
    localparam int PLAYER_X = 40;
    localparam int PLAYER_W = 20;
    localparam int PLAYER_H = 20;
    localparam int GROUND_Y = 180;
    localparam int N_OBST   = 3;
    localparam int OBST_W   = 10;
    localparam int OBST_H   = 20;
    localparam int OBST_GAP = 160;
    localparam int JUMP_V0  = 8;
    localparam int GRAVITY  = 1;
    localparam int SCORE_MAX = 65535;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_OVER = 2;

    localparam int RGB_BLUE31 = 16'h001F;
    localparam int RGB_RED31  = 16'hF800;
    localparam int RGB_OBST   = 16'h0500;
    localparam int RGB_GROUND = 16'h07E0;
    localparam int RGB_SKY    = 16'h03D4;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick, jump, start;
    logic [8:0] x, y;

    logic [4:0]  red_o   [2];
    logic [5:0]  green_o [2];
    logic [4:0]  blue_o  [2];
    logic [8:0]  py_o    [2];
    logic [15:0] score_o [2];
    logic        over_o  [2];

    int errors = 0;
    int checks = 0;

    int speed_of [2] = '{2, 4};
    int m_state  [2];
    int m_py     [2];
    int m_vy     [2];
    int m_score  [2];
    int m_ox     [2][N_OBST];
    int m_lfsr;

    always #5 clock = ~clock;

    runner_game_core dut (
        .clock(clock), .reset(reset), .tick(tick), .jump(jump), .start(start),
        .x(x), .y(y), .red(red_o[0]), .green(green_o[0]), .blue(blue_o[0]),
        .player_y(py_o[0]), .score(score_o[0]), .game_over(over_o[0])
    );

    runner_game_core #(.SPEED(4)) dut_fast (
        .clock(clock), .reset(reset), .tick(tick), .jump(jump), .start(start),
        .x(x), .y(y), .red(red_o[1]), .green(green_o[1]), .blue(blue_o[1]),
        .player_y(py_o[1]), .score(score_o[1]), .game_over(over_o[1])
    );

    // ---------------- reference model ----------------
    function automatic void model_load(input int g);
        m_py[g]    = GROUND_Y;
        m_vy[g]    = 0;
        m_score[g] = 0;
        for (int i = 0; i < N_OBST; i++) m_ox[g][i] = SCREEN_W + i * OBST_GAP;
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < 2; g++) begin
            m_state[g] = ST_IDLE;
            model_load(g);
        end
        m_lfsr = 8'hA5;
    endfunction

    function automatic int rotl8(input int v, input int k);
        return ((v << k) | (v >> (8 - k))) & 255;
    endfunction

    function automatic bit overlap(input int ax, input int aw, input int ay, input int ah,
                                   input int bx, input int bw, input int by, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic void model_tick(input bit j, input bit s);
        bit [7:0] taps;
        int cur, np, nv, hits;
        cur = m_lfsr;
        for (int g = 0; g < 2; g++) begin
            if (m_state[g] != ST_RUN) begin
                if (s) begin
                    model_load(g);
                    m_state[g] = ST_RUN;
                end
            end else begin
                if (m_py[g] == GROUND_Y && m_vy[g] == 0 && j) begin
                    m_vy[g] = -JUMP_V0;
                end else begin
                    np = m_py[g] + m_vy[g];
                    nv = m_vy[g] + GRAVITY;
                    if (np >= GROUND_Y) begin
                        np = GROUND_Y;
                        nv = 0;
                    end
                    m_py[g] = np;
                    m_vy[g] = nv;
                end
                hits = 0;
                for (int i = 0; i < N_OBST; i++) begin
                    if (m_ox[g][i] <= speed_of[g]) begin
                        m_ox[g][i] = SCREEN_W + (rotl8(cur, i) % 128);
                        hits++;
                    end else begin
                        m_ox[g][i] -= speed_of[g];
                    end
                end
                m_score[g] = (m_score[g] + hits > SCORE_MAX) ? SCORE_MAX : m_score[g] + hits;
                for (int i = 0; i < N_OBST; i++) begin
                    if (overlap(PLAYER_X, PLAYER_W, m_py[g] - PLAYER_H, PLAYER_H,
                                m_ox[g][i], OBST_W, GROUND_Y - OBST_H, OBST_H))
                        m_state[g] = ST_OVER;
                end
            end
        end
        taps   = 8'(cur) & 8'hB8;
        m_lfsr = ((cur << 1) | int'(^taps)) & 255;
    endfunction

    function automatic int render(input int g, input int px, input int pyy);
        if (px >= SCREEN_W || pyy >= SCREEN_H) return 0;
        if (overlap(px, 1, pyy, 1, PLAYER_X, PLAYER_W, m_py[g] - PLAYER_H, PLAYER_H))
            return (m_state[g] == ST_OVER) ? RGB_RED31 : RGB_BLUE31;
        for (int i = 0; i < N_OBST; i++)
            if (overlap(px, 1, pyy, 1, m_ox[g][i], OBST_W, GROUND_Y - OBST_H, OBST_H))
                return RGB_OBST;
        if (pyy >= GROUND_Y) return RGB_GROUND;
        return RGB_SKY;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int rgb_of(input int g);
        return int'({red_o[g], green_o[g], blue_o[g]});
    endfunction

    task automatic checkOutput(input string tag);
        for (int g = 0; g < 2; g++) begin
            checkValue($sformatf("%s_py%0d", tag, g), int'(py_o[g]), m_py[g]);
            checkValue($sformatf("%s_score%0d", tag, g), int'(score_o[g]), m_score[g]);
            checkValue($sformatf("%s_over%0d", tag, g), int'(over_o[g]),
                       int'(m_state[g] == ST_OVER));
        end
    endtask

    task automatic applyStimulus(input bit j, input bit s);
        jump  = j;
        start = s;
        tick  = 1'b1;
        @(posedge clock);
        #1;
        tick  = 1'b0;
        model_tick(j, s);
    endtask

    task automatic probePixel(input int px, input int pyy);
        x    = 9'(px);
        y    = 9'(pyy);
        tick = 1'b0;
        @(posedge clock);
        #1;
        for (int g = 0; g < 2; g++)
            checkValue($sformatf("pix%0d_%0d_%0d", g, px, pyy), rgb_of(g), render(g, px, pyy));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int jump_table [17] = '{172, 165, 159, 154, 150, 147, 145, 144, 144,
                                145, 147, 150, 154, 159, 165, 172, 180};
        tick = 0; jump = 0; start = 0; x = 0; y = 0; reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset");
        checkValue("reset_rgb0", rgb_of(0), 0);
        checkValue("reset_rgb1", rgb_of(1), 0);
        reset = 1'b0;

        // IDLE ignores frames without start, then a start enters RUN.
        applyStimulus(0, 0);
        checkOutput("idle");
        applyStimulus(0, 1);
        checkOutput("start");
        checkValue("start_py", int'(py_o[0]), 180);
        checkValue("start_score", int'(score_o[0]), 0);
        probePixel(45, 170);
        checkValue("pix_player", rgb_of(0), RGB_BLUE31);
        probePixel(10, 200);
        checkValue("pix_ground", rgb_of(0), RGB_GROUND);
        probePixel(500, 10);
        checkValue("pix_black", rgb_of(0), 0);
        probePixel(100, 100);
        probePixel(479, 271);

        // No jumping: the fast copy hits at frame 106, the default copy at 211.
        for (int n = 1; n <= 211; n++) begin
            applyStimulus(0, 0);
            checkOutput("run");
            if (n == 105) checkValue("fast_over_105", int'(over_o[1]), 0);
            if (n == 106) checkValue("fast_over_106", int'(over_o[1]), 1);
            if (n == 210) checkValue("over_210", int'(over_o[0]), 0);
            if (n == 211) begin
                checkValue("over_211", int'(over_o[0]), 1);
                checkValue("score_211", int'(score_o[0]), 0);
            end
        end
        probePixel(45, 170);
        checkValue("pix_over_player", rgb_of(0), RGB_RED31);
        probePixel(65, 170);
        checkValue("pix_obst", rgb_of(0), RGB_OBST);
        probePixel(68, 170);

        // OVER freezes the game even if jump is requested.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0);
            checkOutput("frozen");
        end

        // Restart, then one jump pulse from the ground.
        applyStimulus(0, 1);
        checkOutput("restart");
        checkValue("restart_over", int'(over_o[0]), 0);
        checkValue("restart_py", int'(py_o[0]), 180);
        applyStimulus(1, 0);
        checkOutput("jump0");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(0, 0);
            checkOutput("arc");
            checkValue($sformatf("arc_%0d", k + 1), int'(py_o[0]), jump_table[k]);
        end

        // Held jump starts again after landing. A timed jump then clears
        // slot 0 of the fast copy, which respawns at frame 120.
        for (int n = 19; n <= 145; n++) begin
            applyStimulus(n == 19 || n == 20 || n == 100, 0);
            checkOutput("clear");
            if (n == 20)  checkValue("rejump_py", int'(py_o[0]), 172);
            if (n == 119) checkValue("fast_score_119", int'(score_o[1]), 0);
            if (n == 120) begin
                checkValue("fast_score_120", int'(score_o[1]), 1);
                checkValue("fast_alive_120", int'(over_o[1]), 0);
            end
        end
        for (int px = 360; px < SCREEN_W; px++) probePixel(px, 170);

        // Random play with pixel spot checks.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            checkOutput("rand");
            if (n % 3 == 0) probePixel($urandom_range(0, 511), $urandom_range(0, 300));
        end

        // Get the default copy running on the ground, jump, then reset mid-air.
        for (int k = 0; k < 40 && !(m_state[0] == ST_RUN && m_py[0] == GROUND_Y && m_vy[0] == 0); k++) begin
            applyStimulus(0, m_state[0] != ST_RUN);
            checkOutput("settle");
        end
        checkValue("settle_ready", int'(m_state[0] == ST_RUN && m_py[0] == GROUND_Y && m_vy[0] == 0), 1);
        applyStimulus(1, 0);
        checkOutput("mid0");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0);
            checkOutput("mid");
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checkValue("async_py", int'(py_o[0]), 180);
        checkValue("async_score", int'(score_o[0]), 0);
        checkValue("async_over", int'(over_o[0]), 0);
        checkValue("async_rgb", rgb_of(0), 0);
        checkOutput("async");
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(0, 1);
        checkOutput("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
